// File: rtl/nasti_sram_bridge.sv
// NASTI slave endpoint driving a single-port synchronous SRAM, one burst at a time.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   aw_* / w_* / b_*               write address, write data and write response channels
//   ar_* / r_*                     read address and read data channels
//   ram_en, ram_we, ram_addr       SRAM strobe, byte write enables (0 = read), word address
//   ram_wdata, ram_rdata           SRAM write data (mirrors w_data) and read data
module nasti_sram_bridge #(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               aw_valid,
  output logic                                               aw_ready,
  input  logic [ID_WIDTH-1:0]                                aw_id,
  input  logic [ADDR_WIDTH-1:0]                              aw_addr,
  input  logic [7:0]                                         aw_len,
  input  logic [2:0]                                         aw_size,
  input  logic [1:0]                                         aw_burst,
  input  logic                                               w_valid,
  output logic                                               w_ready,
  input  logic [DATA_WIDTH-1:0]                              w_data,
  input  logic [DATA_WIDTH/8-1:0]                            w_strb,
  input  logic                                               w_last,
  output logic                                               b_valid,
  input  logic                                               b_ready,
  output logic [ID_WIDTH-1:0]                                b_id,
  output logic [1:0]                                         b_resp,
  output logic [USER_WIDTH-1:0]                              b_user,
  input  logic                                               ar_valid,
  output logic                                               ar_ready,
  input  logic [ID_WIDTH-1:0]                                ar_id,
  input  logic [ADDR_WIDTH-1:0]                              ar_addr,
  input  logic [7:0]                                         ar_len,
  input  logic [2:0]                                         ar_size,
  input  logic [1:0]                                         ar_burst,
  output logic                                               r_valid,
  input  logic                                               r_ready,
  output logic [ID_WIDTH-1:0]                                r_id,
  output logic [DATA_WIDTH-1:0]                              r_data,
  output logic [1:0]                                         r_resp,
  output logic                                               r_last,
  output logic [USER_WIDTH-1:0]                              r_user,
  output logic                                               ram_en,
  output logic [DATA_WIDTH/8-1:0]                            ram_we,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]                              ram_wdata,
  input  logic [DATA_WIDTH-1:0]                              ram_rdata
);

  localparam int unsigned OffWidth = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {StIdle, StWrData, StWrResp, StRdReq, StRdResp} state_e;

  state_e                  state_q, state_d;
  logic                    aw_ready_q, aw_ready_d, ar_ready_q, ar_ready_d;
  logic                    wr_prio_q, wr_prio_d;  // 1: write wins a simultaneous request
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d, cnt_q, cnt_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic                    err_q, err_d;

  logic                    last_beat;
  logic [31:0]             span;
  logic [ADDR_WIDTH-1:0]   step, incr, wrap_mask, addr_next;

  function automatic logic bad_burst(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] l,
                                     input logic [2:0] s, input logic [1:0] bu);
    logic                  e;
    logic [ADDR_WIDTH-1:0] align;
    align = (ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1);
    e = (32'(s) > OffWidth) || (bu == 2'b11);
    if (bu == 2'b10) begin
      if (!(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)) e = 1'b1;
      if ((a & align) != '0) e = 1'b1;
    end
    return e;
  endfunction

  assign aw_ready  = aw_ready_q;
  assign ar_ready  = ar_ready_q;
  assign last_beat = (cnt_q == len_q);

  // Next beat address; WRAP keeps the bits above the wrap window fixed.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    incr      = addr_q + step;
    span      = (32'(len_q) + 32'd1) << size_q;
    wrap_mask = ADDR_WIDTH'(span - 32'd1);
    case (burst_q)
      2'b00:   addr_next = addr_q;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | (incr & wrap_mask);
      default: addr_next = incr;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    aw_ready_d = 1'b0;
    ar_ready_d = 1'b0;
    wr_prio_d  = wr_prio_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    burst_d    = burst_q;
    err_d      = err_q;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    b_id       = '0;
    b_resp     = 2'b00;
    r_valid    = 1'b0;
    r_id       = '0;
    r_data     = '0;
    r_resp     = 2'b00;
    r_last     = 1'b0;
    ram_en     = 1'b0;
    ram_we     = '0;
    ram_addr   = '0;
    ram_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (aw_valid && aw_ready_q) begin
          {id_d, addr_d, len_d, size_d, burst_d} = {aw_id, aw_addr, aw_len, aw_size, aw_burst};
          cnt_d     = '0;
          err_d     = bad_burst(aw_addr, aw_len, aw_size, aw_burst);
          wr_prio_d = 1'b0;
          state_d   = StWrData;
        end else if (ar_valid && ar_ready_q) begin
          {id_d, addr_d, len_d, size_d, burst_d} = {ar_id, ar_addr, ar_len, ar_size, ar_burst};
          cnt_d     = '0;
          err_d     = bad_burst(ar_addr, ar_len, ar_size, ar_burst);
          wr_prio_d = 1'b1;
          state_d   = StRdReq;
        end else begin
          // Ready is only raised from a settled IDLE cycle, which also enforces
          // at least one IDLE cycle between bursts.
          aw_ready_d = aw_valid && (!ar_valid || wr_prio_q);
          ar_ready_d = ar_valid && (!aw_valid || !wr_prio_q);
        end
      end
      StWrData: begin
        w_ready   = 1'b1;
        ram_addr  = addr_q[ADDR_WIDTH-1:OffWidth];
        ram_wdata = w_data;
        if (w_valid) begin
          ram_en = !err_q;
          ram_we = err_q ? '0 : w_strb;
          if (w_last != last_beat) err_d = 1'b1;
          addr_d = addr_next;
          cnt_d  = cnt_q + 8'd1;
          if (last_beat) state_d = StWrResp;
        end
      end
      StWrResp: begin
        b_valid = 1'b1;
        b_id    = id_q;
        b_resp  = err_q ? 2'b10 : 2'b00;
        if (b_ready) state_d = StIdle;
      end
      StRdReq: begin
        ram_en   = !err_q;
        ram_addr = addr_q[ADDR_WIDTH-1:OffWidth];
        state_d  = StRdResp;
      end
      StRdResp: begin
        r_valid = 1'b1;
        r_id    = id_q;
        r_data  = err_q ? '0 : ram_rdata;
        r_resp  = err_q ? 2'b10 : 2'b00;
        r_last  = last_beat;
        if (r_ready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            addr_d  = addr_next;
            cnt_d   = cnt_q + 8'd1;
            state_d = StRdReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign b_user = '0;
  assign r_user = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      aw_ready_q <= 1'b0;
      ar_ready_q <= 1'b0;
      wr_prio_q  <= 1'b1;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_ready_q <= aw_ready_d;
      ar_ready_q <= ar_ready_d;
      wr_prio_q  <= wr_prio_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/nasti_sram_bridge.md
# nasti_sram_bridge

Slave-side endpoint that terminates all five NASTI channels (`nasti_aw`, `nasti_w`, `nasti_b`, `nasti_ar`, `nasti_r`) and drives a single-port synchronous SRAM. It sits directly downstream of any NASTI master or crossbar port. It executes one burst at a time: a read or write of up to 256 beats with FIXED, INCR or WRAP addressing. Its uses are on-chip scratchpad, boot RAM and the memory models in test benches.

## Interface
Parameters:
- `ID_WIDTH`, 8: bits of `id` used; unused bits of the `MAX_NASTI_ID_WIDTH` field are driven 0.
- `ADDR_WIDTH`, 16: byte-address bits decoded; upper address bits are ignored.
- `DATA_WIDTH`, 64: beat width; power of two, 8..256.
- `USER_WIDTH`, 1: `b.user`/`r.user` are driven 0.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `aw`  interface  nasti_aw  write address; slave side.
- `w`  interface  nasti_w  write data; slave side.
- `b`  interface  nasti_b  write response; slave side.
- `ar`  interface  nasti_ar  read address; slave side.
- `r`  interface  nasti_r  read data; slave side.
- `ram_en`  out  1  SRAM access strobe.
- `ram_we`  out  DATA_WIDTH/8  byte write enables; 0 means read.
- `ram_addr`  out  ADDR_WIDTH-log2(DATA_WIDTH/8)  word address.
- `ram_wdata`  out  DATA_WIDTH  write data; equals `w.data`.
- `ram_rdata`  in  DATA_WIDTH  read data. Valid the cycle after a read `ram_en`; held stable until the next `ram_en`.

## Operation
- FSM states: IDLE, WR_DATA, WR_RESP, RD_REQ, RD_RESP.
- IDLE: `aw.ready` and `ar.ready` are registered outputs. At most one is high in a cycle, and only in IDLE.
  - If only one of `aw.valid`/`ar.valid` is high, that channel is granted.
  - If both are high, the channel not granted last time wins; after reset the write channel wins.
- On address handshake, the block latches `id`, `addr`, `len`, `size`, `burst`, clears the beat counter, and clears the `err` flag.
- `err` is set for:
  - `size` > log2(DATA_WIDTH/8);
  - `burst` == 2'b11;
  - WRAP with `len` not in {1,3,7,15};
  - WRAP with an address not aligned to `size`.
- When `err` is set, no SRAM access is made for the remainder of the burst. All beats are still handshaken. The response is SLVERR (2'b10); otherwise OKAY (2'b00).
- Address update after each beat:
  - FIXED: unchanged.
  - INCR: addr += 1<<size. Wraps modulo 2^ADDR_WIDTH.
  - WRAP: addr = (addr & ~mask) | ((addr + (1<<size)) & mask), with mask = ((len+1)<<size)-1.
- WR_DATA: `w.ready`=1. On each `w` handshake:
  - `ram_en`=1, `ram_we`=`w.strb` (suppressed when `err` is set), `ram_addr`=addr>>log2(DATA_WIDTH/8), in the same cycle.
  - Narrow writes rely on the master's lane strobes.
  - A beat whose `w.last` disagrees with (counter==len) sets `err`. That beat and later beats are still written only if `err` was clear before the beat.
  - The burst ends on beat len+1, regardless of `w.last`. Then go to WR_RESP.
- WR_RESP: `b.valid`=1, `b.id`=latched id, `b.resp` per `err`. Held until `b.ready`, then IDLE.
- RD_REQ: one cycle. `ram_en`=1, `ram_we`=0. Then RD_RESP.
- RD_RESP: `r.valid`=1, `r.data`=`ram_rdata`, `r.id`=latched id, `r.resp` per `err`, `r.last`=(counter==len). When `err` is set, `r.data` is 0.
  - On `r.ready`: if last, go to IDLE; else advance the address and go to RD_REQ.
- All outputs not listed as active in a state are 0.

## Timing
- Reset, asynchronous: state=IDLE; all `valid`/`ready` outputs 0; `ram_en`=0; `ram_we`=0; grant priority to write; `err` cleared.
- Reset mid-burst abandons the burst silently; no B or R is produced.
- Write: AW handshake in cycle 0. `w.ready` high from cycle 1. A burst of N beats with `w.valid` held completes beats in cycles 1..N. `b.valid` rises in cycle N+1.
- Read: AR handshake in cycle 0. `ram_en` in cycle 1. `r.valid` in cycle 2. Peak throughput is one beat per 2 cycles; `r.ready` low stretches RD_RESP.
- Minimum one IDLE cycle between bursts.
- `w` beats arriving before the AW handshake are not accepted (`w.ready`=0).
- `aw`/`ar` payload is sampled only on handshake. Changes while not ready are ignored.

## Test plan
- INCR write, id=5, addr=0x100, len=3, size=3, strb=0xFF, data 1..4 -> SRAM words 0x20..0x23 written in cycles 1..4; `b.valid` in cycle 5 with id=5, resp=OKAY.
- Read-back of the same burst with `r.ready` toggling every other cycle -> data 1,2,3,4; `r.last` only on beat 4; no beat lost or duplicated.
- WRAP read, addr=0x118, len=3, size=3 -> word addresses 0x23,0x20,0x21,0x22. FIXED read with len=2 -> word 0x23 three times.
- `aw.valid` and `ar.valid` asserted together continuously -> grants alternate W,R,W,R starting with write after reset.
- size=4 on a 64-bit bus, len=1 write -> no `ram_en`; two beats accepted; b.resp=SLVERR. Write with `w.last` on beat 1 of len=3 -> 4 beats accepted, resp=SLVERR.
- `rst` asserted during RD_RESP -> `r.valid` drops at once; next AR is accepted normally with OKAY.
